pwm_generator: RTL and testbench
================================

PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 SHALL have parameter PRESCALE, default 13, the number of clk cycles per PWM counter step.
REQ-002 SHALL have port clk, input, 1 bit: system clock; the only clock in the block.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port cfg_valid, input, 1 bit: single-cycle strobe from the SPI register stage marking new configuration.
REQ-005 SHALL have port en_out, input, 16 bits: per-output enable.
REQ-006 SHALL have port en_pwm, input, 16 bits: per-output PWM mode select (1 = PWM, 0 = static high).
REQ-007 SHALL have port duty, input, 8 bits: shared duty cycle, 0x00 to 0xFF.
REQ-008 SHALL have port out, output, 16 bits: registered PWM or static outputs.
REQ-009 SHALL have port period_start, output, 1 bit: one-cycle pulse at the start of each PWM period.

Function
REQ-010 SHALL run a prescaler counting 0 to PRESCALE-1 and wrapping to 0; a tick SHALL occur in the cycle where prescaler equals PRESCALE-1.
REQ-011 SHALL run an 8-bit period counter that increments only on a tick and wraps from 255 to 0, giving a period of 256*PRESCALE clk cycles.
REQ-012 A wrap event SHALL be a tick while the period counter equals 255.
REQ-013 On cfg_valid, the block SHALL capture en_out and en_pwm into internal registers, effective from the next cycle.
REQ-014 On cfg_valid, the block SHALL capture duty into a pending register and set a pending flag.
REQ-015 On a wrap event with the pending flag set, the block SHALL copy pending into the active duty and clear the flag; a duty change SHALL never take effect mid-period.
REQ-016 When cfg_valid and a wrap event coincide, the block SHALL load the duty input directly into the active duty and leave the flag clear.
REQ-017 Repeated cfg_valid within one period SHALL overwrite pending; only the last value SHALL take effect.
REQ-018 The PWM level SHALL be 1 when active duty equals 0xFF, otherwise (period counter < active duty).
REQ-019 Consequence of REQ-018: duty 0x00 SHALL give a constant 0, and duty 0xFF SHALL give a constant 1 with no glitch at wrap.
REQ-020 For each bit i, out[i] SHALL be 0 if en_out[i]=0.
REQ-021 For each bit i, out[i] SHALL be 1 if en_out[i]=1 and en_pwm[i]=0.
REQ-022 For each bit i, out[i] SHALL equal the PWM level if en_out[i]=1 and en_pwm[i]=1.
REQ-023 out SHALL be registered, lagging the period counter state by exactly one clk cycle.
REQ-024 period_start SHALL be a registered one-cycle pulse asserted in the cycle after each wrap event.
REQ-025 The prescaler and period counter SHALL free-run; cfg_valid SHALL never restart them.

Reset
REQ-026 While rst_n=0, the following SHALL be cleared: prescaler, period counter, active duty, pending register, pending flag, captured enables, out (16'h0000) and period_start (0).
REQ-027 Deassertion of rst_n SHALL restart counting from prescaler 0 and period counter 0; assertion mid-period SHALL abort the period immediately.
REQ-028 The first period_start after reset SHALL occur 256*PRESCALE+1 cycles after reset release.

Structure
REQ-029 PRESCALE default, counter width (8) and output count (16) SHALL be constants in the shared project package.
REQ-030 The prescaler SHALL be a sub-module, clk_prescaler, exposing a single-cycle tick output.
REQ-031 All remaining logic SHALL be in pwm_generator; no latches and no derived clocks.

Verification
REQ-032 Scenario (static outputs): cfg_valid with en_out=16'h00FF, en_pwm=16'h0000 -> out=16'h00FF from the 2nd cycle on, period_start still pulsing every 3328 cycles.
REQ-033 Scenario (50% duty): en_out=en_pwm=16'hFFFF, duty=0x80 -> after the next wrap, every period has out=16'hFFFF for 1664 cycles, then 16'h0000 for 1664 cycles.
REQ-034 Scenario (duty extremes): duty=0x00 -> out stays 0 for a full period; duty=0xFF -> out stays 16'hFFFF across two wraps with no low cycle.
REQ-035 Scenario (mid-period change): duty 0x40 active, then cfg_valid with duty=0xC0 at counter 0x10 -> the current period keeps its high time of 832 cycles; the next period has a high time of 2496 cycles.
REQ-036 Scenario (coincident events): cfg_valid on a wrap cycle with duty=0x20 -> the new period high time is 416 cycles; cfg_valid twice in one period (0x10, then 0x30) -> only 0x30 is applied.
REQ-037 Scenario (reset mid-period): rst_n pulsed low at counter 0x50 -> out=0 and period_start=0 asynchronously, and the first period_start arrives 3329 cycles after release.

Source files
------------

// File: rtl/pwm_generator_pkg.sv
// Shared constants and helpers for the PWM generator.
package pwm_generator_pkg;

    localparam int PRESCALE_DEFAULT = 13;
    localparam int CNT_W            = 8;
    localparam int N_OUT            = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Full-scale duty is forced high so the output never dips at the wrap.
    function automatic logic pwm_level(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] duty_val);
        return (duty_val == CNT_MAX) || (cnt < duty_val);
    endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Free-running clock-enable generator: tick is high for one cycle every PRESCALE cycles.
module clk_prescaler
    import pwm_generator_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/pwm_generator.sv
// 16-channel PWM generator with shared duty, per-channel enable and static/PWM select.
module pwm_generator
    import pwm_generator_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    input  logic [N_OUT-1:0] en_out,
    input  logic [N_OUT-1:0] en_pwm,
    input  logic [CNT_W-1:0] duty,
    output logic [N_OUT-1:0] out,
    output logic             period_start
);

    // cfg_valid is a valid-only strobe with no ready: every cycle it is high,
    // en_out/en_pwm/duty are sampled and accepted unconditionally.

    logic             tick;
    logic             wrap;
    logic             level;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] active_duty;
    logic [CNT_W-1:0] pending_duty;
    logic             pending_flag;
    logic [N_OUT-1:0] en_out_q;
    logic [N_OUT-1:0] en_pwm_q;

    clk_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign wrap  = tick && (period_cnt == CNT_MAX);
    assign level = pwm_level(period_cnt, active_duty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (tick) begin
            period_cnt <= period_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_out_q <= '0;
            en_pwm_q <= '0;
        end else if (cfg_valid) begin
            en_out_q <= en_out;
            en_pwm_q <= en_pwm;
        end
    end

    // Duty only moves into the active register at a period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_duty  <= '0;
            pending_duty <= '0;
            pending_flag <= 1'b0;
        end else if (cfg_valid && wrap) begin
            active_duty  <= duty;
            pending_duty <= duty;
            pending_flag <= 1'b0;
        end else if (cfg_valid) begin
            pending_duty <= duty;
            pending_flag <= 1'b1;
        end else if (wrap && pending_flag) begin
            active_duty  <= pending_duty;
            pending_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            out          <= en_out_q & (~en_pwm_q | {N_OUT{level}});
            period_start <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed and randomized bench for pwm_generator against a cycle-count reference model.
module tb_pwm_generator;
    import pwm_generator_pkg::*;

    localparam int P   = PRESCALE_DEFAULT;
    localparam int PER = 256 * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] en_out = '0;
    logic [15:0] en_pwm = '0;
    logic [7:0]  duty = '0;
    logic [15:0] out;
    logic        period_start;

    pwm_generator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .en_out      (en_out),
        .en_pwm      (en_pwm),
        .duty        (duty),
        .out         (out),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: time since release, applied duty, pending writes, captured enables.
    int          m_t;
    logic [7:0]  m_active;
    logic [7:0]  pend_q[$];
    logic [15:0] m_en_out;
    logic [15:0] m_en_pwm;

    logic [15:0] cur_eo;
    logic [15:0] cur_ep;
    logic [7:0]  cur_d;

    task automatic model_reset();
        m_t      = 0;
        m_active = 8'h00;
        pend_q.delete();
        m_en_out = '0;
        m_en_pwm = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, compare outputs.
    task automatic step(input logic cfg);
        int          pos;
        int          pc;
        logic        wrap;
        logic        lvl;
        logic [15:0] exp_out;
        cfg_valid = cfg;
        if (cfg) begin
            en_out = cur_eo;
            en_pwm = cur_ep;
            duty   = cur_d;
        end else begin
            en_out = 16'($urandom);
            en_pwm = 16'($urandom);
            duty   = 8'($urandom);
        end
        pos     = m_t % PER;
        pc      = pos / P;
        wrap    = (pos == PER - 1);
        lvl     = (m_active == 8'hFF) || (pc < int'(m_active));
        exp_out = m_en_out & (~m_en_pwm | {16{lvl}});
        if (cfg) begin
            m_en_out = cur_eo;
            m_en_pwm = cur_ep;
        end
        if (wrap && cfg) begin
            m_active = cur_d;
            pend_q.delete();
        end else begin
            if (wrap && pend_q.size() > 0) begin
                m_active = pend_q[$];
                pend_q.delete();
            end
            if (cfg) pend_q.push_back(cur_d);
        end
        m_t++;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        check("out", 32'(out), 32'(exp_out));
        check("period_start", 32'(period_start), 32'(wrap));
    endtask

    // Waits for period_start, then counts cycles with out[0] high across one full period,
    // optionally issuing duty writes when the period counter reaches pc1 / pc2.
    task automatic measure(input int pc1, input logic [7:0] d1,
                           input int pc2, input logic [7:0] d2, output int hi);
        int waited = 0;
        bit seen   = 0;
        int pc;
        while (!seen && waited < PER + 8) begin
            step(1'b0);
            waited++;
            if (period_start === 1'b1) seen = 1;
        end
        check("period_sync", 32'(seen), 32'd1);
        hi = (out[0] === 1'b1) ? 1 : 0;
        for (int i = 1; i < PER; i++) begin
            pc = (m_t % PER) / P;
            if ((m_t % P == 0) && pc == pc1) begin
                cur_d = d1;
                step(1'b1);
            end else if ((m_t % P == 0) && pc == pc2) begin
                cur_d = d2;
                step(1'b1);
            end else begin
                step(1'b0);
            end
            hi += (out[0] === 1'b1) ? 1 : 0;
        end
    endtask

    // Counts cycles from release (release cycle = 1) to the first period_start.
    task automatic first_period_start();
        int n    = 1;
        bit seen = 0;
        while (!seen && n < PER + 10) begin
            step(1'b0);
            n++;
            if (period_start === 1'b1) seen = 1;
        end
        check("first_period_start", 32'(n), 32'(PER + 1));
    endtask

    task automatic configure(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        cur_eo = eo;
        cur_ep = ep;
        cur_d  = d;
        step(1'b1);
    endtask

    initial begin
        int hi;
        int guard;
        cur_eo = '0;
        cur_ep = '0;
        cur_d  = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 32'(out), 32'h0);
        check("reset_period_start", 32'(period_start), 32'h0);
        rst_n = 1'b1;
        first_period_start();

        // Static outputs on the low byte.
        configure(16'h00FF, 16'h0000, 8'h00);
        step(1'b0);
        check("static_out", 32'(out), 32'h00FF);
        measure(-1, 8'h00, -1, 8'h00, hi);
        check("static_high", 32'(hi), 32'(PER));
        step(1'b0);
        check("static_period_start", 32'(period_start), 32'd1);

        // 50% duty, applied from the next wrap.
        configure(16'hFFFF, 16'hFFFF, 8'h80);
        measure(-1, 8'h00, -1, 8'h00, hi);
        check("duty80_p1", 32'(hi), 32'(128 * P));
        measure(-1, 8'h00, -1, 8'h00, hi);
        check("duty80_p2", 32'(hi), 32'(128 * P));

        // Extremes; these writes land on a wrap cycle.
        configure(16'hFFFF, 16'hFFFF, 8'h00);
        measure(-1, 8'h00, -1, 8'h00, hi);
        check("duty00", 32'(hi), 32'd0);
        configure(16'hFFFF, 16'hFFFF, 8'hFF);
        measure(-1, 8'h00, -1, 8'h00, hi);
        check("dutyFF_p1", 32'(hi), 32'(PER));
        measure(-1, 8'h00, -1, 8'h00, hi);
        check("dutyFF_p2", 32'(hi), 32'(PER));

        // Mid-period change must wait for the boundary.
        configure(16'hFFFF, 16'hFFFF, 8'h40);
        measure(8'h10, 8'hC0, -1, 8'h00, hi);
        check("mid_keep_40", 32'(hi), 32'(64 * P));
        measure(8'h90, 8'h70, -1, 8'h00, hi);
        check("mid_next_C0", 32'(hi), 32'(192 * P));

        // Write on the wrap overrides the stale pending 0x70.
        configure(16'hFFFF, 16'hFFFF, 8'h20);
        measure(-1, 8'h00, -1, 8'h00, hi);
        check("coincident_20", 32'(hi), 32'(32 * P));
        measure(8'h08, 8'h10, 8'h40, 8'h30, hi);
        check("no_stale_pending", 32'(hi), 32'(32 * P));
        measure(-1, 8'h00, -1, 8'h00, hi);
        check("last_write_30", 32'(hi), 32'(48 * P));

        // Randomized configuration traffic.
        for (int i = 0; i < 2 * PER; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                cur_eo = 16'($urandom);
                cur_ep = 16'($urandom);
                case ($urandom_range(0, 3))
                    0:       cur_d = 8'h00;
                    1:       cur_d = 8'hFF;
                    default: cur_d = 8'($urandom);
                endcase
                step(1'b1);
            end else begin
                step(1'b0);
            end
        end

        // Asynchronous reset mid-period.
        configure(16'hFFFF, 16'h0000, 8'h00);
        step(1'b0);
        guard = 0;
        while (((m_t % PER) / P) != 8'h50 && guard < PER + 8) begin
            step(1'b0);
            guard++;
        end
        check("pre_reset_out", 32'(out), 32'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", 32'(out), 32'h0);
        check("async_reset_period_start", 32'(period_start), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        first_period_start();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
